// File: rtl/md_pkg.sv
// Shared types for the multi-cycle multiply/divide unit.
// Holds the operation encoding, the FSM state encoding and a helper that
// tells signed operations apart from unsigned ones.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_PREP,
    S_DIV_ITER,
    S_DIV_FIX
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring divider core on unsigned magnitudes, one quotient bit per cycle.
// Latency: WIDTH cycles after the load edge; done is high once all bits are produced.
// No backpressure: the caller holds off load until the previous result is taken.
// Ports: clk, reset (sync, active-high), load, dividend, divisor -> quotient, remainder, done.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      // A set borrow bit means the trial subtraction went negative: restore.
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign done      = (cnt == '0);

endmodule

// File: rtl/md_unit_mc.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Latency: MUL_CYCLES busy cycles for multiply, WIDTH+2 for divide; HI/LO update as busy drops.
// Backpressure: busy stalls the pipeline; start/hi_we/lo_we are ignored while busy, cancel aborts.
// Ports: clk, reset (sync, active-high), start, op, a, b, hi_we, lo_we, cancel -> busy, hi, lo.
module md_unit_mc
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  md_state_t          state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  md_op_t             op_in, op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               launch, div_load, div_done;
  logic               wr_hi, wr_lo;
  logic [WIDTH-1:0]   hi_val, lo_val;
  logic               sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_fix, r_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign op_in = md_op_t'(op);

  // Sign handling for both datapaths, all from the latched operands.
  always_comb begin
    sgn      = md_is_signed(op_q);
    a_neg    = sgn & a_q[WIDTH-1];
    b_neg    = sgn & b_q[WIDTH-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    a_ext    = {{WIDTH{a_neg}}, a_q};
    b_ext    = {{WIDTH{b_neg}}, b_q};
    // Low 2*WIDTH bits of the extended product are the exact signed/unsigned result.
    prod     = a_ext * b_ext;
    q_fix    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    r_fix    = a_neg ? (~r_mag + 1'b1) : r_mag;
    div_zero = (b_q == '0);
    div_ovf  = (op_q == MD_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (q_mag),
    .remainder (r_mag),
    .done      (div_done)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    div_load  = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    hi_val    = a;
    lo_val    = a;
    case (state)
      S_IDLE: begin
        if (start) begin
          // A same-cycle start always drops the MTHI/MTLO write.
          if (!cancel) begin
            launch    = 1'b1;
            state_nxt = op_in[1] ? S_DIV_PREP : S_MUL;
            cnt_nxt   = '0;
          end
        end else begin
          wr_hi = hi_we;
          wr_lo = lo_we;
        end
      end
      S_MUL: begin
        if (cnt == CW'(MUL_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          wr_hi     = 1'b1;
          wr_lo     = 1'b1;
          hi_val    = prod[2*WIDTH-1:WIDTH];
          lo_val    = prod[WIDTH-1:0];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DIV_PREP: begin
        div_load  = 1'b1;
        state_nxt = S_DIV_ITER;
        cnt_nxt   = '0;
      end
      S_DIV_ITER: begin
        if (cnt == CW'(WIDTH - 1)) state_nxt = S_DIV_FIX;
        else                       cnt_nxt   = cnt + CW'(1);
      end
      S_DIV_FIX: begin
        if (div_done) begin
          state_nxt = S_IDLE;
          wr_hi     = 1'b1;
          wr_lo     = 1'b1;
          if (div_zero) begin
            hi_val = a_q;
            lo_val = '1;
          end else if (div_ovf) begin
            hi_val = '0;
            lo_val = a_q;
          end else begin
            hi_val = r_fix;
            lo_val = q_fix;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Flush aborts any in-flight op, including its final HI/LO write.
    if (cancel && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      div_load  = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != S_IDLE);
      if (launch) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_in;
      end
      if (wr_hi) hi <= hi_val;
      if (wr_lo) lo <= lo_val;
    end
  end

endmodule

// File: tb/tb_md_unit_mc.sv
module tb_md_unit_mc;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we, cancel;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit_mc #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = ux * uy;      rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == 0) begin
          rl = 32'hFFFF_FFFF; rh = x;
        end else if (o == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = x; rh = 32'h0;
        end else if (o == 2'b10) begin
          rl = 32'(sx / sy); rh = 32'(sx % sy);
        end else begin
          rl = x / y; rh = x % y;
        end
      end
    endcase
  endtask

  // Monitor: counts busy cycles and scores each completion against the queue.
  initial begin
    int   bcnt;
    logic prev;
    exp_t e;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        bcnt++;
      end else begin
        if (prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got busy drop after %0d cycles expected none", bcnt);
          end else begin
            e = exp_q.pop_front();
            chk("result_hi", hi, e.hi);
            chk("result_lo", lo, e.lo);
            chk("busy_cycles", 32'(bcnt), 32'(e.cycles));
          end
        end
        bcnt = 0;
      end
      prev = (busy === 1'b1);
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL completion_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
    @(posedge clk); #1;
    hi_we = hw; lo_we = lw; a = v;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0; a = $urandom;
    if (hw) m_hi = v;
    if (lw) m_lo = v;
    @(negedge clk);
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  // kill_at: busy cycle in which cancel (or reset) is pulsed, 0 = none.
  // poke_at: busy cycle in which a spurious start+MTHI is driven, 0 = none.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int kill_at, input bit kill_rst, input int poke_at);
    exp_t        e;
    logic [31:0] rh, rl;
    int          lat;
    lat = o[1] ? 34 : 5;
    ref_op(o, x, y, rh, rl);
    if (kill_at == 0) begin
      e.hi = rh; e.lo = rl; e.cycles = lat;
      m_hi = rh; m_lo = rl;
    end else if (kill_rst) begin
      e.hi = 0; e.lo = 0; e.cycles = kill_at;
      m_hi = 0; m_lo = 0;
    end else begin
      e.hi = m_hi; e.lo = m_lo; e.cycles = kill_at;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom; op = 2'($urandom);
    for (int c = 1; c <= lat; c++) begin
      if (c == poke_at) begin
        start = 1; hi_we = 1; lo_we = 1'($urandom); a = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
      if (c == kill_at) begin
        if (kill_rst) reset = 1; else cancel = 1;
      end
      @(posedge clk); #1;
      start = 0; hi_we = 0; lo_we = 0; cancel = 0; reset = 0;
      if (c == kill_at) break;
    end
    drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 99));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1; start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; cancel = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    mt(1, 0, 32'h1234);
    mt(0, 1, 32'h5678);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'b10, 32'd5, 32'd0, 0, 0, 0);
    run_op(2'b11, 32'd5, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);

    mt(1, 1, 32'h0);
    mt(1, 0, 32'h1234);
    mt(0, 1, 32'h5678);
    run_op(2'b00, 32'd9, 32'd9, 3, 0, 0);
    run_op(2'b11, 32'd1000, 32'd33, 0, 0, 2);
    run_op(2'b00, 32'd7, 32'd6, 5, 0, 0);
    run_op(2'b10, 32'd77, 32'd5, 34, 0, 0);
    run_op(2'b10, 32'd77, 32'd5, 1, 0, 0);

    mt(1, 1, 32'hCAFE_F00D);
    run_op(2'b10, 32'd500, 32'd3, 10, 1, 0);

    // start with cancel while idle: nothing launches, nothing is written.
    mt(1, 0, 32'hAAAA_0001);
    @(posedge clk); #1;
    start = 1; cancel = 1; hi_we = 1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 0; cancel = 0; hi_we = 0;
    @(negedge clk);
    chk("idle_cancel_busy", 32'(busy), 32'h0);
    chk("idle_cancel_hi", hi, m_hi);
    repeat (3) @(negedge clk);
    chk("idle_cancel_busy_later", 32'(busy), 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      int         lat, k, p;
      bit         r;
      o   = 2'($urandom);
      lat = o[1] ? 34 : 5;
      k   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
      r   = (k != 0) && ($urandom_range(0, 3) == 0);
      p   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
      run_op(o, pick(), pick(), k, r, p);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
